// File: rtl/pcie_tx_arbiter.sv
// Packet-granular weighted round-robin arbiter sharing one PCIe TX AXI4-Stream
// between the PIO/completion engine (src0) and the Ethernet injection path (src1).
module pcie_tx_arbiter #(
   parameter int C_DATA_WIDTH = 64,
   parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
   parameter int SRC0_WEIGHT  = 1
) (
   input  logic                    pcie_clk,
   input  logic                    pcie_rst_n,
   input  logic                    s0_tvalid,
   output logic                    s0_tready,
   input  logic                    s0_tlast,
   input  logic [KEEP_WIDTH-1:0]   s0_tkeep,
   input  logic [C_DATA_WIDTH-1:0] s0_tdata,
   input  logic [3:0]              s0_tuser,
   input  logic                    s1_tvalid,
   output logic                    s1_tready,
   input  logic                    s1_tlast,
   input  logic [KEEP_WIDTH-1:0]   s1_tkeep,
   input  logic [C_DATA_WIDTH-1:0] s1_tdata,
   input  logic [3:0]              s1_tuser,
   input  logic                    s1_en,
   output logic                    m_tvalid,
   input  logic                    m_tready,
   output logic                    m_tlast,
   output logic [KEEP_WIDTH-1:0]   m_tkeep,
   output logic [C_DATA_WIDTH-1:0] m_tdata,
   output logic [3:0]              m_tuser,
   output logic [1:0]              grant,
   output logic [31:0]             pkt_cnt0,
   output logic [31:0]             pkt_cnt1
);

   // State encodings double as the one-hot grant value.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      GRANT0 = 2'b01,
      GRANT1 = 2'b10
   } state_t;

   localparam logic [3:0] WEIGHT = 4'(SRC0_WEIGHT);

   state_t      state_reg;
   logic        last_owner_reg;
   logic [3:0]  burst_cnt_reg;
   logic [31:0] pkt_cnt0_reg;
   logic [31:0] pkt_cnt1_reg;

   logic req0;
   logic req1;
   logic src1_wins;
   logic eop;

   assign req0      = s0_tvalid;
   assign req1      = s1_tvalid & s1_en;
   assign src1_wins = !last_owner_reg && (burst_cnt_reg >= WEIGHT);
   assign eop       = m_tvalid & m_tready & m_tlast;

   assign grant    = state_reg;
   assign pkt_cnt0 = pkt_cnt0_reg;
   assign pkt_cnt1 = pkt_cnt1_reg;

   always_comb begin
      m_tvalid  = 1'b0;
      m_tlast   = 1'b0;
      m_tkeep   = '0;
      m_tdata   = '0;
      m_tuser   = '0;
      s0_tready = 1'b0;
      s1_tready = 1'b0;
      case (state_reg)
         GRANT0: begin
            m_tvalid  = s0_tvalid;
            m_tlast   = s0_tlast;
            m_tkeep   = s0_tkeep;
            m_tdata   = s0_tdata;
            m_tuser   = s0_tuser;
            s0_tready = m_tready;
         end
         GRANT1: begin
            m_tvalid  = s1_tvalid;
            m_tlast   = s1_tlast;
            m_tkeep   = s1_tkeep;
            m_tdata   = s1_tdata;
            m_tuser   = s1_tuser;
            s1_tready = m_tready;
         end
         default: ;
      endcase
   end

   // last_owner resets to 1 so source 0 wins the first contention.
   always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
      if (!pcie_rst_n) begin
         state_reg      <= IDLE;
         last_owner_reg <= 1'b1;
         burst_cnt_reg  <= 4'd0;
         pkt_cnt0_reg   <= 32'd0;
         pkt_cnt1_reg   <= 32'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req0 && req1)
                  state_reg <= src1_wins ? GRANT1 : GRANT0;
               else if (req0)
                  state_reg <= GRANT0;
               else if (req1)
                  state_reg <= GRANT1;
            end
            GRANT0: begin
               if (eop) begin
                  state_reg      <= IDLE;
                  pkt_cnt0_reg   <= pkt_cnt0_reg + 32'd1;
                  last_owner_reg <= 1'b0;
                  if (burst_cnt_reg != 4'hF)
                     burst_cnt_reg <= burst_cnt_reg + 4'd1;
               end
            end
            GRANT1: begin
               if (eop) begin
                  state_reg      <= IDLE;
                  pkt_cnt1_reg   <= pkt_cnt1_reg + 32'd1;
                  last_owner_reg <= 1'b1;
                  burst_cnt_reg  <= 4'd0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
